row_scan_ctrl: RTL



---
 rtl/scan_pkg.sv | 13 +
 rtl/row_scan_ctrl_if.sv | 26 ++
 rtl/scan_timer.sv | 31 +++
 rtl/row_scan_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and sizes for the row scan controller.
package scan_pkg;

  localparam int NUM_ROWS = 16;
  localparam int ROW_W    = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } scan_state_e;

endpackage

// File: rtl/row_scan_ctrl_if.sv
// Command, sense and decoder-select signals of the row scan controller.
interface row_scan_ctrl_if;
  import scan_pkg::*;

  logic                start;
  logic                continuous;
  logic                abort;
  logic                sense;
  logic [ROW_W-1:0]    row_sel;
  logic                row_en;
  logic                busy;
  logic [NUM_ROWS-1:0] frame;
  logic                frame_valid;

  // Host side: issues commands and returns the sense line.
  modport master (
    output start, continuous, abort, sense,
    input  row_sel, row_en, busy, frame, frame_valid
  );

  // Controller side.
  modport slave (
    input  start, continuous, abort, sense,
    output row_sel, row_en, busy, frame, frame_valid
  );
endinterface

// File: rtl/scan_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wrapping on terminal count.
module scan_timer #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc,
  output logic sample
);

  logic [CNT_W-1:0] count_q;

  assign tc     = (count_q == CNT_W'(DWELL - 1));
  assign sample = (count_q == CNT_W'(SETTLE));

  // Count register; clear has priority so each row starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tc ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/row_scan_ctrl.sv
// Walks the row decoder through all rows, samples sense once per row and
// publishes the assembled frame with a one-cycle valid pulse.
module row_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input logic            clk,
  input logic            rst,
  row_scan_ctrl_if.slave bus
);

  // Row 15 must be sampled before its terminal count loads the frame.
  if (DWELL < 2 || DWELL > 255 || SETTLE < 0 || SETTLE > DWELL - 2 ||
      CNT_W < 1 || CNT_W > 31 || (DWELL - 1) >= (1 << CNT_W)) begin : g_param_check
    $error("row_scan_ctrl: illegal DWELL/SETTLE/CNT_W combination");
  end

  scan_state_e         state_q;
  logic [ROW_W-1:0]    row_sel_q;
  logic                row_en_q;
  logic                busy_q;
  logic [NUM_ROWS-1:0] frame_q;
  logic                frame_valid_q;
  logic [NUM_ROWS-1:0] shadow_q;

  logic timer_clear;
  logic timer_enable;
  logic tc;
  logic sample;
  logic last_row;

  assign timer_enable = (state_q == StScan);
  // Outside SCAN the counter is held at zero so every scan begins at count 0.
  assign timer_clear  = (state_q != StScan) || bus.abort;
  assign last_row     = (row_sel_q == ROW_W'(NUM_ROWS - 1));

  scan_timer #(
    .DWELL  (DWELL),
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .tc     (tc),
    .sample (sample)
  );

  // Scan FSM with row counter, shadow sample register and frame output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      row_sel_q     <= '0;
      row_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      shadow_q      <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.abort) begin
            state_q   <= StScan;
            row_sel_q <= '0;
            row_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            shadow_q  <= '0;
          end
        end
        StScan: begin
          if (bus.abort) begin
            state_q   <= StIdle;
            row_sel_q <= '0;
            row_en_q  <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            if (sample) begin
              shadow_q[row_sel_q] <= bus.sense;
            end
            if (tc) begin
              if (last_row) begin
                state_q       <= StDone;
                frame_q       <= shadow_q;
                frame_valid_q <= 1'b1;
                row_en_q      <= 1'b0;
                row_sel_q     <= '0;
              end else begin
                row_sel_q <= row_sel_q + 1'b1;
              end
            end
          end
        end
        StDone: begin
          if (bus.continuous && !bus.abort) begin
            state_q   <= StScan;
            row_sel_q <= '0;
            row_en_q  <= 1'b1;
            shadow_q  <= '0;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          row_sel_q <= '0;
          row_en_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.row_sel     = row_sel_q;
  assign bus.row_en      = row_en_q;
  assign bus.busy        = busy_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;

endmodule
